// File: rtl/rom_arb_pkg.sv
// Shared constants and types for the program ROM arbiter.
package rom_arb_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 18;

  typedef enum logic {ARB, LOCK} arb_state_t;
  typedef enum logic {OWN_FETCH, OWN_DBG} owner_t;

endpackage

// File: rtl/prog_rom_arbiter_if.sv
// Requester/ROM signal bundle; slave = arbiter side, master = fetch/debug/ROM side.
interface prog_rom_arbiter_if #(
  parameter int unsigned ADDR_W = rom_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W = rom_arb_pkg::DATA_W
);
  logic              FETCH_REQ;
  logic [ADDR_W-1:0] FETCH_ADDR;
  logic              FETCH_GNT;
  logic              FETCH_VALID;
  logic [DATA_W-1:0] FETCH_RDATA;
  logic              DBG_REQ;
  logic [ADDR_W-1:0] DBG_ADDR;
  logic              DBG_LOCK;
  logic              DBG_GNT;
  logic              DBG_VALID;
  logic [DATA_W-1:0] DBG_RDATA;
  logic [ADDR_W-1:0] ROM_ADDR;
  logic [DATA_W-1:0] ROM_DATA;

  modport slave (
    input  FETCH_REQ, FETCH_ADDR, DBG_REQ, DBG_ADDR, DBG_LOCK, ROM_DATA,
    output FETCH_GNT, FETCH_VALID, FETCH_RDATA,
    output DBG_GNT, DBG_VALID, DBG_RDATA, ROM_ADDR
  );

  modport master (
    output FETCH_REQ, FETCH_ADDR, DBG_REQ, DBG_ADDR, DBG_LOCK, ROM_DATA,
    input  FETCH_GNT, FETCH_VALID, FETCH_RDATA,
    input  DBG_GNT, DBG_VALID, DBG_RDATA, ROM_ADDR
  );
endinterface

// File: rtl/rom_arb_resp_pipe.sv
// Owner tag stage tracking each in-flight ROM read, plus per-requester
// registered read data and one-cycle valid pulses.
module rom_arb_resp_pipe
  import rom_arb_pkg::*;
#(
  parameter int unsigned DATA_W = rom_arb_pkg::DATA_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              acc_i,
  input  owner_t            owner_i,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              fetch_valid_o,
  output logic [DATA_W-1:0] fetch_rdata_o,
  output logic              dbg_valid_o,
  output logic [DATA_W-1:0] dbg_rdata_o
);

  logic              s1_vld_q;
  owner_t            s1_own_q;
  logic              fetch_valid_q;
  logic [DATA_W-1:0] fetch_rdata_q;
  logic              dbg_valid_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_vld_q      <= 1'b0;
      s1_own_q      <= OWN_FETCH;
      fetch_valid_q <= 1'b0;
      fetch_rdata_q <= '0;
      dbg_valid_q   <= 1'b0;
      dbg_rdata_q   <= '0;
    end else begin
      s1_vld_q      <= acc_i;
      s1_own_q      <= owner_i;
      fetch_valid_q <= s1_vld_q && (s1_own_q == OWN_FETCH);
      dbg_valid_q   <= s1_vld_q && (s1_own_q == OWN_DBG);
      // ROM output is only captured by the requester that owns this read
      if (s1_vld_q && (s1_own_q == OWN_FETCH)) fetch_rdata_q <= rom_data_i;
      if (s1_vld_q && (s1_own_q == OWN_DBG))   dbg_rdata_q   <= rom_data_i;
    end
  end

  assign fetch_valid_o = fetch_valid_q;
  assign fetch_rdata_o = fetch_rdata_q;
  assign dbg_valid_o   = dbg_valid_q;
  assign dbg_rdata_o   = dbg_rdata_q;

endmodule

// File: rtl/prog_rom_arbiter.sv
// Shares the synchronous-read program ROM between MCU fetch and debug reads.
// Optional DBG anti-starvation: define ROM_ARB_FAIRNESS_EN.
module prog_rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = rom_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W   = rom_arb_pkg::DATA_W,
  parameter int unsigned MAX_WAIT = 8
) (
  input logic              CLK,
  input logic              RST_N,
  prog_rom_arbiter_if.slave bus
);

  arb_state_t state_q;
  logic       lock_hold;
  logic       force_dbg;
  logic       fetch_gnt;
  logic       dbg_gnt;

`ifdef ROM_ARB_FAIRNESS_EN
  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);
  logic [3:0] wait_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                         wait_q <= '0;
    else if (!bus.DBG_REQ || dbg_gnt)   wait_q <= '0;
    else                                wait_q <= wait_q + 4'd1;
  end

  assign force_dbg = (wait_q == WAIT_LIM);
`else
  assign force_dbg = 1'b0;
`endif

  // Lock is released in the same cycle DBG_LOCK drops, so that cycle arbitrates normally
  always_comb begin
    lock_hold = (state_q == LOCK) && bus.DBG_LOCK;
    dbg_gnt   = RST_N && bus.DBG_REQ && (lock_hold || force_dbg || !bus.FETCH_REQ);
    fetch_gnt = RST_N && bus.FETCH_REQ && !lock_hold && !dbg_gnt;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ARB;
    end else begin
      case (state_q)
        ARB:     if (dbg_gnt && bus.DBG_LOCK) state_q <= LOCK;
        LOCK:    if (!bus.DBG_LOCK)           state_q <= ARB;
        default:                              state_q <= ARB;
      endcase
    end
  end

  assign bus.FETCH_GNT = fetch_gnt;
  assign bus.DBG_GNT   = dbg_gnt;
  assign bus.ROM_ADDR  = dbg_gnt ? bus.DBG_ADDR : bus.FETCH_ADDR;

  rom_arb_resp_pipe #(
    .DATA_W (DATA_W)
  ) u_resp_pipe (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .acc_i         (fetch_gnt || dbg_gnt),
    .owner_i       (dbg_gnt ? OWN_DBG : OWN_FETCH),
    .rom_data_i    (bus.ROM_DATA),
    .fetch_valid_o (bus.FETCH_VALID),
    .fetch_rdata_o (bus.FETCH_RDATA),
    .dbg_valid_o   (bus.DBG_VALID),
    .dbg_rdata_o   (bus.DBG_RDATA)
  );

endmodule

// File: tb/tb_prog_rom_arbiter.sv
// Bench for prog_rom_arbiter: ROM model, per-cycle reference model, directed tests.
module tb_prog_rom_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 18;
  localparam int unsigned MW = 8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   cyc;

  prog_rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  prog_rom_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_WAIT (MW)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {a[7:0] ^ 8'hA5, a};
  endfunction

  always @(posedge clk) bus.ROM_DATA <= rom_word(bus.ROM_ADDR);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: pending reads due at accept-cycle+2, held read data,
  // lock flag and DBG wait count, all evaluated from the arbitration rules.
  typedef struct {
    int          due;
    bit          dbg;
    logic [AW-1:0] addr;
  } rsp_t;

  rsp_t          pend[$];
  rsp_t          r;
  logic [DW-1:0] m_frd, m_drd;
  bit            m_locked;
  int            m_wait;
  bit            e_fv, e_dv, e_fg, e_dg, lk, frc;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pend.delete();
      m_frd = '0; m_drd = '0; m_locked = 0; m_wait = 0;
      chk("rst_fetch_gnt",   32'(bus.FETCH_GNT),   32'd0);
      chk("rst_dbg_gnt",     32'(bus.DBG_GNT),     32'd0);
      chk("rst_fetch_valid", 32'(bus.FETCH_VALID), 32'd0);
      chk("rst_dbg_valid",   32'(bus.DBG_VALID),   32'd0);
      chk("rst_fetch_rdata", 32'(bus.FETCH_RDATA), 32'd0);
      chk("rst_dbg_rdata",   32'(bus.DBG_RDATA),   32'd0);
      chk("rst_rom_addr",    32'(bus.ROM_ADDR),    32'(bus.FETCH_ADDR));
    end else begin
      e_fv = 0; e_dv = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        r = pend.pop_front();
        if (r.dbg) begin e_dv = 1; m_drd = rom_word(r.addr); end
        else       begin e_fv = 1; m_frd = rom_word(r.addr); end
      end
      chk("fetch_valid", 32'(bus.FETCH_VALID), 32'(e_fv));
      chk("dbg_valid",   32'(bus.DBG_VALID),   32'(e_dv));
      chk("fetch_rdata", 32'(bus.FETCH_RDATA), 32'(m_frd));
      chk("dbg_rdata",   32'(bus.DBG_RDATA),   32'(m_drd));

      lk  = m_locked && bus.DBG_LOCK;
`ifdef ROM_ARB_FAIRNESS_EN
      frc = (m_wait == MW) && bus.DBG_REQ;
`else
      frc = 0;
`endif
      e_dg = bus.DBG_REQ && (lk || frc || !bus.FETCH_REQ);
      e_fg = bus.FETCH_REQ && !lk && !e_dg;
      chk("fetch_gnt", 32'(bus.FETCH_GNT), 32'(e_fg));
      chk("dbg_gnt",   32'(bus.DBG_GNT),   32'(e_dg));
      chk("rom_addr",  32'(bus.ROM_ADDR),  32'(e_dg ? bus.DBG_ADDR : bus.FETCH_ADDR));

      if (e_fg || e_dg) pend.push_back('{cyc + 2, e_dg, e_dg ? bus.DBG_ADDR : bus.FETCH_ADDR});
      m_locked = bus.DBG_LOCK && (m_locked || e_dg);
      m_wait   = (bus.DBG_REQ && !e_dg) ? m_wait + 1 : 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int first;

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    rst_n = 1'b0;
    bus.FETCH_REQ = 1'b0; bus.FETCH_ADDR = '0;
    bus.DBG_REQ = 1'b0; bus.DBG_ADDR = '0; bus.DBG_LOCK = 1'b0;
    tick(); tick();
    chk("lit_rst_fetch_valid", 32'(bus.FETCH_VALID), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single fetch at 0x005
    bus.FETCH_REQ = 1'b1; bus.FETCH_ADDR = 10'h005;
    #1 chk("lit_t1_gnt", 32'(bus.FETCH_GNT), 32'd1);
    tick();
    bus.FETCH_REQ = 1'b0;
    tick();
    chk("lit_t1_valid", 32'(bus.FETCH_VALID), 32'd1);
    chk("lit_t1_rdata", 32'(bus.FETCH_RDATA), 32'h28005);
    chk("lit_t1_dbg_valid", 32'(bus.DBG_VALID), 32'd0);
    tick();

    // Back-to-back fetches 0,1,2
    bus.FETCH_REQ = 1'b1; bus.FETCH_ADDR = 10'h000;
    tick();
    bus.FETCH_ADDR = 10'h001;
    tick();
    chk("lit_t2_v0", 32'(bus.FETCH_VALID), 32'd1);
    chk("lit_t2_d0", 32'(bus.FETCH_RDATA), 32'h29400);
    bus.FETCH_ADDR = 10'h002;
    tick();
    chk("lit_t2_v1", 32'(bus.FETCH_VALID), 32'd1);
    chk("lit_t2_d1", 32'(bus.FETCH_RDATA), 32'h29001);
    bus.FETCH_REQ = 1'b0;
    tick();
    chk("lit_t2_v2", 32'(bus.FETCH_VALID), 32'd1);
    chk("lit_t2_d2", 32'(bus.FETCH_RDATA), 32'h29C02);
    tick(); tick();

    // FETCH and DBG contend for 20 cycles
    first = 0;
    bus.FETCH_REQ = 1'b1; bus.DBG_REQ = 1'b1; bus.DBG_ADDR = 10'h3FF;
    for (int i = 1; i <= 20; i++) begin
      bus.FETCH_ADDR = 10'(i + 16);
`ifdef ROM_ARB_FAIRNESS_EN
      if (first != 0 && i == first + 2) begin
        chk("lit_t3_dbg_valid", 32'(bus.DBG_VALID), 32'd1);
        chk("lit_t3_dbg_rdata", 32'(bus.DBG_RDATA), 32'h16BFF);
      end
`endif
      #1;
      if (bus.DBG_GNT && first == 0) begin
        first = i;
        chk("lit_t3_fetch_blocked", 32'(bus.FETCH_GNT), 32'd0);
      end
      tick();
    end
`ifdef ROM_ARB_FAIRNESS_EN
    chk("lit_t3_first_dbg_gnt", 32'(first), 32'd9);
`else
    chk("lit_t3_first_dbg_gnt", 32'(first), 32'd0);
`endif
    bus.FETCH_REQ = 1'b0; bus.DBG_REQ = 1'b0;
    tick(); tick(); tick();

    // Locked debug burst blocks FETCH until DBG_LOCK drops
    bus.DBG_REQ = 1'b1; bus.DBG_LOCK = 1'b1; bus.DBG_ADDR = 10'h055;
    #1 chk("lit_t4_dbg_gnt", 32'(bus.DBG_GNT), 32'd1);
    tick();
    bus.FETCH_REQ = 1'b1; bus.FETCH_ADDR = 10'h0AA;
    for (int c = 1; c <= 4; c++) begin
      bus.DBG_ADDR = 10'(10'h060 + c);
      #1 chk("lit_t4_fetch_locked_out", 32'(bus.FETCH_GNT), 32'd0);
      tick();
    end
    bus.DBG_LOCK = 1'b0; bus.DBG_REQ = 1'b0;
    #1 chk("lit_t4_fetch_after_unlock", 32'(bus.FETCH_GNT), 32'd1);
    tick();
    bus.FETCH_REQ = 1'b0;
    tick(); tick(); tick();

    // Reset one cycle after an accepted fetch
    bus.FETCH_REQ = 1'b1; bus.FETCH_ADDR = 10'h123;
    tick();
    rst_n = 1'b0;
    #1;
    chk("lit_t5_gnt_in_rst",   32'(bus.FETCH_GNT),   32'd0);
    chk("lit_t5_valid_in_rst", 32'(bus.FETCH_VALID), 32'd0);
    chk("lit_t5_rdata_in_rst", 32'(bus.FETCH_RDATA), 32'd0);
    chk("lit_t5_addr_in_rst",  32'(bus.ROM_ADDR),    32'h123);
    tick();
    rst_n = 1'b1; bus.FETCH_REQ = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("lit_t5_no_stale_valid", 32'(bus.FETCH_VALID), 32'd0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
